// File: rtl/hansen_dmem_mmio_if.sv
// Data-memory port between the core's MEM stage and the data-side memory subsystem.
interface hansen_dmem_mmio_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;

  modport master (output dmem_addr, output dmem_wdata, output dmem_we, input dmem_rdata);
  modport slave  (input dmem_addr, input dmem_wdata, input dmem_we, output dmem_rdata);
endinterface

// File: rtl/hansen_dmem_mmio.sv
// Data RAM plus MMIO window: UART transmitter (8N1) behind a TX FIFO, and a free-running cycle counter.
module hansen_dmem_mmio #(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                reset,
  hansen_dmem_mmio_if.slave   bus,
  output logic                uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [FW:0]   FULL_CNT    = (FW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  localparam logic [31:0] ADDR_TXDATA = 32'h8000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
  localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0008;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wptr, rptr;
  logic [FW:0]   count;
  logic          overflow;
  logic [31:0]   cycle;

  state_t        state_q, state_n;
  logic [BW-1:0] baud_q, baud_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    shift_q, shift_n;

  logic          sel_ram, sel_tx, sel_status, sel_cycle;
  logic [AW-1:0] ram_idx;
  logic          full, empty, push_req, push, pop;
  logic [31:0]   status_word;

  assign sel_ram    = (bus.dmem_addr[31:28] == 4'h0);
  assign sel_tx     = (bus.dmem_addr == ADDR_TXDATA);
  assign sel_status = (bus.dmem_addr == ADDR_STATUS);
  assign sel_cycle  = (bus.dmem_addr == ADDR_CYCLE);
  assign ram_idx    = bus.dmem_addr[AW+1:2];

  // Fullness and emptiness are taken from pre-edge state, so a same-edge pop never frees a slot for a push.
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_req = bus.dmem_we && sel_tx;
  assign push     = push_req && !full;
  assign pop      = (state_q == IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (bus.dmem_we && sel_ram)
      ram[ram_idx] <= bus.dmem_wdata;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wptr] <= bus.dmem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      cycle <= '0;
    else if (bus.dmem_we && sel_cycle)
      cycle <= bus.dmem_wdata;
    else
      cycle <= cycle + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
    end
    shift_q <= shift_n;
  end

  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    uart_tx = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          shift_n = fifo_mem[rptr];
          baud_n  = BAUD_RELOAD;
          state_n = START;
        end
      end
      START: begin
        uart_tx = 1'b0;
        if (baud_q == '0) begin
          baud_n  = BAUD_RELOAD;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_q - 1'b1;
        end
      end
      DATA: begin
        uart_tx = shift_q[0];
        if (baud_q == '0) begin
          baud_n  = BAUD_RELOAD;
          shift_n = {1'b0, shift_q[7:1]};
          bit_n   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_n = STOP;
        end else begin
          baud_n = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_q == '0) state_n = IDLE;
        else              baud_n  = baud_q - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    status_word       = '0;
    status_word[0]    = full;
    status_word[1]    = empty && (state_q == IDLE);
    status_word[2]    = overflow;
    status_word[15:8] = 8'(count);
  end

  always_comb begin
    bus.dmem_rdata = '0;
    if (sel_ram)         bus.dmem_rdata = ram[ram_idx];
    else if (sel_status) bus.dmem_rdata = status_word;
    else if (sel_cycle)  bus.dmem_rdata = cycle;
  end

endmodule

// File: doc/hansen_dmem_mmio.md
# hansen_dmem_mmio

Data-side memory subsystem attached directly to the core's data memory port (dmem_addr / dmem_wdata / dmem_we / dmem_rdata); it consumes the MEM stage's requests. It provides word-addressed data RAM plus a memory-mapped I/O window containing a UART transmitter with TX FIFO and a free-running cycle counter. Reads are combinational and side-effect-free, because the core samples dmem_rdata at the edge that ends MEM and drives dmem_addr every cycle, including for non-memory instructions.

## Interface
- RAM_WORDS, 1024: data RAM depth in 32-bit words; power of 2.
- FIFO_DEPTH, 8: UART TX FIFO depth in bytes; power of 2, ≥2.
- CLKS_PER_BIT, 868: clock cycles per UART bit; ≥2.

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dmem_addr  in  32  byte address from the MEM stage; bits [1:0] ignored.
- dmem_wdata  in  32  store data.
- dmem_we  in  1  write strobe; a write occurs at the rising edge while high.
- dmem_rdata  out  32  combinational read data for dmem_addr.
- uart_tx  out  1  serial output, 8N1, LSB first, idle high.

## Operation
- Address decode, evaluated on full dmem_addr:
  - addr[31:28]==0x0 selects RAM. Word index = addr[log2(RAM_WORDS)+1:2]. Higher bits within the window alias.
  - 0x8000_0000 is TXDATA. A write pushes wdata[7:0] into the FIFO. A read returns 0.
  - 0x8000_0004 is STATUS. Read-only; writes are ignored. Fields:
    - bit0 tx_full
    - bit1 tx_idle, meaning FIFO empty and FSM in IDLE
    - bit2 overflow, sticky
    - bits[15:8] FIFO count
    - all other bits 0
  - 0x8000_0008 is CYCLE. A read returns the current counter. A write loads wdata.
  - Any other address reads 0, and writes to it are ignored.
- RAM:
  - Asynchronous read; synchronous write.
  - Contents are not cleared by reset.
  - A read of the address being written in the same cycle returns the old data.
- TX FIFO:
  - Circular buffer with read and write pointers, plus a count of width log2(FIFO_DEPTH)+1.
  - Push when full: the byte is dropped and overflow is set. Fullness is evaluated before the edge, so a pop at the same edge does not make room.
  - overflow is cleared only by reset.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE with FIFO non-empty (pre-edge): pop the head byte into the shift register, load the baud counter with CLKS_PER_BIT-1, go to START.
  - START: uart_tx=0. When the baud counter reaches 0, reload it, clear the bit index, go to DATA.
  - DATA: uart_tx=shift[0]. At each baud-counter expiry, shift right and increment the bit index. After bit 7 expires, go to STOP.
  - STOP: uart_tx=1. At expiry, go to IDLE.
  - IDLE: uart_tx=1.
- CYCLE counter:
  - Increments every cycle; wraps 0xFFFF_FFFF→0.
  - A write at the same edge takes priority over the increment, so the counter holds wdata after the edge.

## Timing
- Reset values after a reset edge:
  - uart_tx=1
  - FSM IDLE
  - FIFO empty, count 0
  - overflow 0
  - CYCLE 0
  - dmem_rdata follows the decode of these reset values; for example STATUS reads 0x0000_0002.
- Reset while a frame is in progress aborts it: uart_tx is 1 from the cycle after the reset edge, and FIFO contents are discarded.
- Read latency is 0 cycles (combinational). Write effects are visible to reads from the cycle after the write edge.
- Push at edge E0 with FSM in IDLE and FIFO empty:
  - pop at E1
  - start bit from E1 to E1+CLKS_PER_BIT
  - whole frame lasts 10×CLKS_PER_BIT cycles, returning to IDLE at E1+10·CLKS_PER_BIT
- Back-to-back frames have exactly 1 IDLE cycle (uart_tx=1) between the stop bit and the next start bit.
- STATUS.count reflects pushes and pops of the previous edge.
- A simultaneous push and pop with the FIFO non-empty and not full leaves count unchanged.

## Test plan
- RAM store/load and aliasing: write 0xDEAD_BEEF @0x0000_0010 → reads 0xDEAD_BEEF at 0x10 and at 0x10+4·RAM_WORDS; 0x0000_0013 returns the same word.
- Serial frame (CLKS_PER_BIT=4): write 0x55 to TXDATA → uart_tx sampled every 4 cycles from E1 reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop); STATUS reads 0x2 after 41 cycles.
- Overflow (CLKS_PER_BIT=4, FIFO_DEPTH=8): 10 back-to-back writes 0x00..0x09 → first byte popped at E1, 7 accepted into FIFO, 0x08 accepted (count 8, full), 0x09 dropped; STATUS bit0=1, bit2=1; serial output carries 0x00–0x08 only, with 1 idle cycle between frames.
- CYCLE: write 0xFFFF_FFFE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on the next three cycles; a read at 0x8000_0008 has no side effect.
- Reset mid-frame during DATA bit 3 → uart_tx=1 next cycle; STATUS=0x0000_0002; CYCLE=0; a RAM word written before reset is still readable.
- Unmapped/MMIO reads: 0x8000_000C and 0x4000_0000 read 0 and writes to them change nothing; a TXDATA read returns 0; a STATUS write leaves STATUS unchanged.
